// File: rtl/adpll_pkg.sv
// adpll_pkg: shared ADPLL constants for the DCO control word and loop filter defaults
package adpll_pkg;
    localparam int CTRL_W = 5;
    localparam int CTRL_MAX = 31;
    localparam logic SIGN_FAST = 1'b0;
    localparam int DEF_INT_W = 10;
    localparam int DEF_INT_FRAC = 2;
endpackage

// File: rtl/sat_sm_conv.sv
// sat_sm_conv: clamp a signed value to +/-CTRL_MAX and split it into sign/magnitude
module sat_sm_conv
    import adpll_pkg::*;
#(
    parameter int W = 11
)(
    input  logic signed [W-1:0]      val,
    output logic                     sign,
    output logic        [CTRL_W-1:0] mag
);
    logic signed [W-1:0] a;

    always_comb begin
        sign = (val < 0) ? ~SIGN_FAST : SIGN_FAST;
        a = (val < 0) ? -val : val;
        mag = (a > CTRL_MAX) ? CTRL_W'(CTRL_MAX) : a[CTRL_W-1:0];
    end
endmodule

// File: rtl/loop_filter_pi.sv
// loop_filter_pi: two-stage PI loop filter driving the DCO sign-magnitude control word,
// with a run-length lock detector on the incoming phase error.
module loop_filter_pi
    import adpll_pkg::*;
#(
    parameter int INT_W = DEF_INT_W,
    parameter int INT_FRAC = DEF_INT_FRAC,
    parameter int LOCK_TOL = 1,
    parameter int LOCK_COUNT = 8
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              err_valid,
    input  logic              err_sign,
    input  logic [4:0]        err,
    input  logic [2:0]        kp,
    input  logic [2:0]        ki,
    input  logic              freeze,
    input  logic              int_clr,
    output logic              ctrl_sign,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ctrl_valid,
    output logic              locked
);
    localparam int P_W = 10;
    localparam int Y_W = (P_W > INT_W ? P_W : INT_W) + 1;
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int I_MAX = 2 ** (INT_W - 1) - 1;

    logic signed [5:0]       e;
    logic signed [P_W-1:0]   p_next, p_reg;
    logic signed [INT_W:0]   i_sum;
    logic signed [INT_W-1:0] i_sat, i_reg;
    logic signed [Y_W-1:0]   y;
    logic                    valid1, y_sign;
    logic [CTRL_W-1:0]       y_mag;
    logic [CNT_W-1:0]        cnt;

    always_comb begin
        e = err_sign ? -$signed({1'b0, err}) : $signed({1'b0, err});
        p_next = P_W'(e) * P_W'($signed({1'b0, kp}));
        i_sum = (INT_W+1)'(i_reg) + (INT_W+1)'(e) * (INT_W+1)'($signed({1'b0, ki}));
        i_sat = i_sum > I_MAX ? INT_W'(I_MAX) : i_sum < -I_MAX ? INT_W'(-I_MAX) : i_sum[INT_W-1:0];
        y = Y_W'(p_reg) + Y_W'(i_reg >>> INT_FRAC);
    end

    sat_sm_conv #(.W(Y_W)) u_conv (
        .val  (y),
        .sign (y_sign),
        .mag  (y_mag)
    );

    // int_clr acts even without a sample and beats freeze
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg <= '0;
            i_reg <= '0;
            valid1 <= 1'b0;
            ctrl_sign <= SIGN_FAST;
            ctrl <= '0;
            ctrl_valid <= 1'b0;
            cnt <= '0;
            locked <= 1'b0;
        end else begin
            valid1 <= err_valid;
            ctrl_valid <= valid1;
            if (err_valid)
                p_reg <= p_next;
            if (int_clr)
                i_reg <= '0;
            else if (err_valid && !freeze)
                i_reg <= i_sat;
            if (valid1) begin
                ctrl_sign <= y_sign;
                ctrl <= y_mag;
            end
            if (err_valid) begin
                if (err <= 5'(LOCK_TOL)) begin
                    cnt <= (cnt == CNT_W'(LOCK_COUNT)) ? cnt : cnt + 1'b1;
                    locked <= cnt >= CNT_W'(LOCK_COUNT - 1);
                end else begin
                    cnt <= '0;
                    locked <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_loop_filter_pi.sv
// tb_loop_filter_pi: directed and randomized checks of loop_filter_pi against an
// integer-arithmetic PI / lock model with a timed expectation queue.
module tb_loop_filter_pi;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       err_valid = 1'b0;
    logic       err_sign = 1'b0;
    logic [4:0] err = '0;
    logic [2:0] kp = '0;
    logic [2:0] ki = '0;
    logic       freeze = 1'b0;
    logic       int_clr = 1'b0;
    logic       ctrl_sign;
    logic [4:0] ctrl;
    logic       ctrl_valid;
    logic       locked;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int m_i = 0;
    int run = 0;
    bit lock_next = 0;
    int lock_due = -1;
    bit exp_locked = 0;
    bit last_s = 0;
    int last_m = 0;
    int due_q[$];
    bit sgn_q[$];
    int mag_q[$];

    loop_filter_pi dut (
        .clk        (clk),
        .reset      (reset),
        .err_valid  (err_valid),
        .err_sign   (err_sign),
        .err        (err),
        .kp         (kp),
        .ki         (ki),
        .freeze     (freeze),
        .int_clr    (int_clr),
        .ctrl_sign  (ctrl_sign),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .locked     (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int floor4(input int v);
        return (v >= 0) ? v / 4 : -((-v + 3) / 4);
    endfunction

    // one input cycle: drive after negedge, update the model, return just past the posedge
    task automatic step(input bit v, input bit s, input int m, input bit clr);
        int e, y;
        @(negedge clk);
        #1;
        err_valid = v;
        err_sign = s;
        err = 5'(m);
        int_clr = clr;
        e = s ? -m : m;
        if (clr)
            m_i = 0;
        else if (v && !freeze) begin
            m_i = m_i + e * int'(ki);
            m_i = (m_i > 511) ? 511 : (m_i < -511) ? -511 : m_i;
        end
        if (v) begin
            y = e * int'(kp) + floor4(m_i);
            y = (y > 31) ? 31 : (y < -31) ? -31 : y;
            due_q.push_back(cyc + 2);
            sgn_q.push_back(y < 0);
            mag_q.push_back(y < 0 ? -y : y);
            run = (m <= 1) ? ((run < 8) ? run + 1 : 8) : 0;
            lock_next = (run >= 8);
            lock_due = cyc + 1;
        end
        @(posedge clk);
        #1;
        err_valid = 1'b0;
        int_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic model_reset();
        due_q.delete();
        sgn_q.delete();
        mag_q.delete();
        m_i = 0;
        run = 0;
        lock_next = 0;
        lock_due = -1;
        exp_locked = 0;
        last_s = 0;
        last_m = 0;
    endtask

    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            total++;
            if (ctrl_valid !== 1'b1) begin
                bad++;
                $display("FAIL mon_valid cyc=%0d got ctrl_valid=%b want 1", cyc, ctrl_valid);
            end
            last_s = sgn_q.pop_front();
            last_m = mag_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            total++;
            if (ctrl_valid !== 1'b0) begin
                bad++;
                $display("FAIL mon_idle cyc=%0d got ctrl_valid=%b want 0", cyc, ctrl_valid);
            end
        end
        total++;
        if ({ctrl_sign, ctrl} !== {last_s, 5'(last_m)}) begin
            bad++;
            $display("FAIL mon_ctrl cyc=%0d got sign=%b ctrl=%0d want sign=%b ctrl=%0d",
                     cyc, ctrl_sign, ctrl, last_s, last_m);
        end
        if (cyc == lock_due) exp_locked = lock_next;
        total++;
        if (locked !== exp_locked) begin
            bad++;
            $display("FAIL mon_locked cyc=%0d got %b want %b", cyc, locked, exp_locked);
        end
    end

    task automatic test_reset();
        total++;
        if ({ctrl_sign, ctrl, ctrl_valid, locked} !== 8'd0) begin
            bad++;
            $display("FAIL reset_initial got %b want 0", {ctrl_sign, ctrl, ctrl_valid, locked});
        end
        reset = 1'b0;
        kp = 3'd3;
        ki = 3'd2;
        for (int i = 0; i < 10; i++) step(1, i[0], 1, 0);
        step(1, 0, 9, 0);
        step(1, 1, 14, 0);
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({ctrl_sign, ctrl, ctrl_valid, locked} !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid got %b want 0", {ctrl_sign, ctrl, ctrl_valid, locked});
        end
        idle(2);
        reset = 1'b0;
        idle(3);
        total++;
        if ({ctrl_valid, ctrl} !== 6'd0) begin
            bad++;
            $display("FAIL reset_after got valid=%b ctrl=%0d want 0/0", ctrl_valid, ctrl);
        end
    endtask

    task automatic test_pi_basic();
        freeze = 0;
        step(0, 0, 0, 1);
        kp = 3'd2;
        ki = 3'd1;
        step(1, 0, 3, 0);
        idle(1);
        total++;
        if ({ctrl_valid, ctrl_sign, ctrl} !== {1'b1, 1'b0, 5'd6}) begin
            bad++;
            $display("FAIL pi_first got valid=%b sign=%b ctrl=%0d want 1/0/6", ctrl_valid, ctrl_sign, ctrl);
        end
        step(1, 0, 3, 0);
        idle(1);
        total++;
        if ({ctrl_sign, ctrl} !== {1'b0, 5'd7}) begin
            bad++;
            $display("FAIL pi_second got sign=%b ctrl=%0d want 0/7", ctrl_sign, ctrl);
        end
    endtask

    task automatic test_sign();
        step(0, 0, 0, 1);
        kp = 3'd1;
        ki = 3'd0;
        step(1, 1, 5, 0);
        idle(1);
        total++;
        if ({ctrl_sign, ctrl} !== {1'b1, 5'd5}) begin
            bad++;
            $display("FAIL sign_neg got sign=%b ctrl=%0d want 1/5", ctrl_sign, ctrl);
        end
        step(1, 1, 0, 0);
        idle(1);
        total++;
        if ({ctrl_valid, ctrl_sign, ctrl} !== {1'b1, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL sign_negzero got valid=%b sign=%b ctrl=%0d want 1/0/0", ctrl_valid, ctrl_sign, ctrl);
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 1);
        kp = 3'd7;
        ki = 3'd7;
        for (int i = 0; i < 4; i++) step(1, 0, 31, 0);
        idle(1);
        total++;
        if ({ctrl_sign, ctrl} !== {1'b0, 5'd31} || m_i != 511) begin
            bad++;
            $display("FAIL sat_pos got sign=%b ctrl=%0d model_i=%0d want 0/31/511", ctrl_sign, ctrl, m_i);
        end
        kp = 3'd0;
        for (int i = 0; i < 3; i++) step(1, 1, 31, 0);
        idle(1);
        total++;
        if ({ctrl_sign, ctrl} !== {1'b1, 5'd31}) begin
            bad++;
            $display("FAIL sat_neg got sign=%b ctrl=%0d want 1/31", ctrl_sign, ctrl);
        end
    endtask

    task automatic test_freeze_clr();
        step(0, 0, 0, 1);
        kp = 3'd0;
        ki = 3'd3;
        step(1, 0, 2, 0);
        freeze = 1;
        for (int i = 0; i < 4; i++) step(1, 0, 2, 0);
        idle(1);
        total++;
        if ({ctrl_sign, ctrl} !== {1'b0, 5'd1}) begin
            bad++;
            $display("FAIL freeze_hold got sign=%b ctrl=%0d want 0/1", ctrl_sign, ctrl);
        end
        step(0, 0, 0, 1);
        step(1, 0, 2, 0);
        idle(1);
        total++;
        if ({ctrl_valid, ctrl} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL int_clr got valid=%b ctrl=%0d want 1/0", ctrl_valid, ctrl);
        end
        freeze = 0;
    endtask

    task automatic test_lock();
        step(1, 0, 2, 0);
        for (int i = 0; i < 7; i++) step(1, i[0], 1, 0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_seven got %b want 0", locked);
        end
        step(1, 0, 1, 1);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL lock_eighth got %b want 1", locked);
        end
        step(1, 1, 2, 0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_drop got %b want 0", locked);
        end
        for (int i = 0; i < 7; i++) step(1, 0, i % 2, 0);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_rerun got %b want 0", locked);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                kp = 3'($urandom);
                ki = 3'($urandom);
            end
            freeze = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 31),
                 $urandom_range(0, 15) == 0);
        end
        freeze = 0;
        idle(4);
        total++;
        if (due_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain got %0d pending outputs want 0", due_q.size());
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_pi_basic();
        test_sign();
        test_saturation();
        test_freeze_clr();
        test_lock();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/loop_filter_pi.md
Name: loop_filter_pi

Overview:
Digital proportional-integral loop filter for the ADPLL, placed directly upstream of the 5-bit DCO. It consumes sign-magnitude phase-error samples from the phase detector and produces the DCO's sign-magnitude control word (ctrl_sign, ctrl[4:0]). It also flags lock when the error stays small for a programmable run of samples.

Parameters:
INT_W, 10, integrator width in bits, signed two's complement
INT_FRAC, 2, integrator fractional bits; the integrator contributes INT >>> INT_FRAC to the output
LOCK_TOL, 1, largest |error| magnitude counted as in-lock
LOCK_COUNT, 8, consecutive in-tolerance samples needed to assert locked

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
err_valid  input  1  one-cycle strobe; err_sign/err are valid this cycle
err_sign  input  1  0 = DCO lags the reference (speed up); 1 = DCO leads
err  input  5  phase-error magnitude
kp  input  3  proportional gain, unsigned
ki  input  3  integral gain, unsigned
freeze  input  1  integrator hold
int_clr  input  1  synchronous integrator clear
ctrl_sign  output  1  to DCO ctrl_sign; 0 = faster
ctrl  output  5  to DCO ctrl; magnitude
ctrl_valid  output  1  one-cycle pulse when ctrl updates
locked  output  1  lock indicator

Behaviour:
- Reset (asynchronous, active-high): integrator=0, stage-1 registers=0, ctrl_sign=0, ctrl=0, ctrl_valid=0, lock counter=0, locked=0.
- Input conversion: e = err_sign ? -err : +err, held as 6-bit signed. Negative zero (sign=1, err=0) gives e=0.
- Stage 1, on err_valid:
  - P = e*kp, signed, at least 9 bits.
  - If int_clr: I <= 0. Otherwise, if freeze: I holds. Otherwise: I <= sat(I + e*ki), clamped to [-(2^(INT_W-1)-1), 2^(INT_W-1)-1], i.e. ±511 at the default width.
  - int_clr takes priority over freeze. int_clr also clears I in any cycle it is asserted without err_valid.
  - Register P and the updated I together with valid1.
- Stage 2, on valid1:
  - y = P + (I >>> INT_FRAC), arithmetic shift (floor).
  - Clamp y to [-31, +31].
  - ctrl_sign <= (y<0); ctrl <= |y|. y=0 gives sign 0.
  - ctrl_valid pulses.
- Latency: ctrl and ctrl_valid update 2 clk cycles after the err_valid cycle.
- Throughput: one sample per cycle; back-to-back err_valid is fully supported.
- ctrl/ctrl_sign hold their last value between updates. The DCO samples them continuously.
- Lock detect, per err_valid sample:
  - If err <= LOCK_TOL: counter increments, saturating at LOCK_COUNT. Otherwise: counter=0 and locked=0 in the next cycle.
  - locked is set in the cycle after the sample that brings the counter to LOCK_COUNT.
  - freeze and int_clr do not affect the lock logic.
- Reset mid-operation clears everything immediately, including in-flight stage-1 data. No ctrl_valid is produced for samples accepted before reset.
- Gain or freeze changes take effect on the next err_valid. No glitch on the outputs, which are registered.

Decomposition:
- Shared package (adpll_pkg) constants: CTRL_W=5, CTRL_MAX=31, the sign-convention constant (SIGN_FAST=0), and the default INT_W / INT_FRAC.
- Natural sub-module: sat_sm_conv. It clamps a signed value to ±CTRL_MAX and splits it into sign/magnitude. The same function will serve the TDC path later.

Test Plan:
- Reset: assert reset mid-stream → outputs 0, locked=0 immediately, no ctrl_valid afterwards until new samples arrive.
- kp=2, ki=1, e=+3 → two cycles later ctrl_valid=1, ctrl_sign=0, ctrl=6 (P=6, I=3, 3>>>2=0). Second e=+3 → ctrl=7 (I=6, 6>>>2=1).
- kp=1, ki=0, e: sign=1, err=5 → ctrl_sign=1, ctrl=5. Negative zero (sign=1, err=0) → ctrl_sign=0, ctrl=0.
- Saturation: kp=7, ki=7, e=+31 back-to-back → ctrl=31 on each pulse; I=217, 434, then clamps at 511. Drive e=-31 with kp=0 until I<0 → output goes negative, clamped at ctrl_sign=1, ctrl=31.
- freeze=1 with ki=3, 4 samples of e=+2 → I unchanged. int_clr one cycle → I=0; the next sample with kp=0 gives ctrl=0.
- Lock: 8 samples with err=1 → locked=1 the cycle after the 8th. One sample with err=2 → locked=0 the next cycle. 7 more in-tolerance samples → locked stays 0.
